hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Produces the per-boundary stall/flush controls consumed by the pipeline registers: PC (fetch), i2d, d2e, e2m, m2w.
- Resolves D-cache miss, I-cache miss, load-use and branch-mispredict hazards using a fixed priority.
- Holds a pending-flush flag so a mispredict that coincides with a D-cache stall is not lost.
- Holds the pipeline for a programmable number of cycles after reset so the caches can initialise.

Parameters:
- RESET_HOLD_CYCLES, 4: cycles of full stall after reset release; 0 means no hold.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ic_miss  in  1  I-cache miss, level, held until fill completes
- dc_miss  in  1  D-cache miss in MEM, level
- ex_mispredict  in  1  one-cycle pulse, branch in EX resolved mispredicted
- ex_is_load  in  1  EX-stage instruction is a load
- ex_uses_rw  in  1  EX-stage instruction writes a register
- ex_rw_addr  in  5  EX-stage destination register
- dec_uses_rs  in  1  decode reads rs
- dec_rs_addr  in  5  decode rs
- dec_uses_rt  in  1  decode reads rt
- dec_rt_addr  in  5  decode rt
- pc_stall  out  1  hold the PC register
- i2d_stall, i2d_flush  out  1 each  i2d register control
- d2e_stall, d2e_flush  out  1 each  d2e register control
- e2m_stall, e2m_flush  out  1 each  e2m register control
- m2w_stall, m2w_flush  out  1 each  m2w register control
- hold_active  out  1  high while in HOLD
- cnt_dc, cnt_ic, cnt_lu, cnt_flush  out  CNT_W each  performance counters

Behaviour:
- State register: HOLD, RUN. Also a hold counter (log2 of RESET_HOLD_CYCLES+1 bits) and a pend_flush flag.
- Reset (asynchronous, while rst_n=0):
  - State=HOLD (RUN if RESET_HOLD_CYCLES=0), counter=RESET_HOLD_CYCLES, pend_flush=0, counters=0.
  - Outputs are decoded from state, so during reset all *_stall=1 and all *_flush=0.
- HOLD:
  - All five stalls=1, all flushes=0, hold_active=1.
  - Counter decrements each clk; moves to RUN on the edge where the counter is 1.
  - Inputs are ignored, including ex_mispredict.
- RUN: outputs are combinational from inputs plus pend_flush. Priority, first match wins, unlisted outputs are 0:
  1. dc_miss=1: pc, i2d, d2e and e2m stall; m2w_flush=1. If ex_mispredict=1 this cycle, set pend_flush.
  2. ex_mispredict=1 or pend_flush=1: i2d_flush=1, d2e_flush=1, pc_stall=ic_miss. Clear pend_flush at the clock edge. Load-use is ignored.
  3. Load-use: ex_is_load, ex_uses_rw, ex_rw_addr!=0, and (dec_uses_rs and dec_rs_addr==ex_rw_addr, or dec_uses_rt and dec_rt_addr==ex_rw_addr). Response: pc and i2d stall, d2e_flush=1.
  4. ic_miss=1: pc_stall=1, i2d_flush=1.
  5. Otherwise: all zero.
- Invariant: a stall and a flush are never both asserted on the same boundary, because registers ignore flush while stalled.
- pend_flush survives any length of dc_miss. It is applied in exactly one cycle, the first cycle after dc_miss falls.
- Register writes $zero: never causes a load-use stall.
- Reset mid-operation: returns to HOLD immediately and drops pend_flush.
- Counters increment once per cycle in which the matching priority branch fires (1, 4, 3, 2 respectively). They saturate at all-ones and never wrap.

Optional Feature:
- Macro HAZARD_SEQ_PERF_COUNTERS_EN.
  - Defined: counters as above.
  - Undefined: counter registers are not built and all cnt_* outputs are constant 0.
  - Stall/flush behaviour is identical either way.

Test Plan:
- Reset with RESET_HOLD_CYCLES=4, rst_n released → all stalls=1 and hold_active=1 for exactly 4 clks; first RUN cycle with idle inputs gives all outputs 0.
- Load-use: ex_is_load=1, ex_rw_addr=5, dec_uses_rt=1, dec_rt_addr=5 → pc_stall=1, i2d_stall=1, d2e_flush=1. Repeat with ex_rw_addr=0 → all outputs 0.
- dc_miss held 10 cycles with ex_mispredict pulsed in cycle 3 → cycles 1-10 show dc response and no i2d/d2e flush. Cycle 11 (dc_miss=0) gives i2d_flush=d2e_flush=1; cycle 12 gives 0.
- ex_mispredict together with a load-use match and ic_miss=1 → i2d_flush=1, d2e_flush=1, pc_stall=1, i2d_stall=0.
- rst_n asserted mid-way through a pending flush, then released (RESET_HOLD_CYCLES=0) → first RUN cycle has no flush.
- Macro defined, counters preloaded near saturation (CNT_W=4), 20 dc_miss cycles → cnt_dc reads 15 and holds. Macro undefined → cnt_dc reads 0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: per-boundary stall/flush for PC, i2d, d2e, e2m, m2w.
// Latency: stall/flush outputs are combinational from inputs in RUN; the reset hold lasts RESET_HOLD_CYCLES clocks.
// Backpressure: dc_miss stalls everything upstream of MEM; a mispredict seen under dc_miss is deferred, not lost.
// Ports: clk/rst_n; hazard inputs (ic_miss, dc_miss, ex_mispredict, EX dest / decode source operands);
//        per-boundary *_stall/*_flush, hold_active, saturating counters cnt_dc/cnt_ic/cnt_lu/cnt_flush.
// Optional: define HAZARD_SEQ_PERF_COUNTERS_EN to build the counters; otherwise cnt_* are tied to 0.
module hazard_sequencer #(
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ic_miss,
    input  logic             dc_miss,
    input  logic             ex_mispredict,
    input  logic             ex_is_load,
    input  logic             ex_uses_rw,
    input  logic [4:0]       ex_rw_addr,
    input  logic             dec_uses_rs,
    input  logic [4:0]       dec_rs_addr,
    input  logic             dec_uses_rt,
    input  logic [4:0]       dec_rt_addr,
    output logic             pc_stall,
    output logic             i2d_stall,
    output logic             i2d_flush,
    output logic             d2e_stall,
    output logic             d2e_flush,
    output logic             e2m_stall,
    output logic             e2m_flush,
    output logic             m2w_stall,
    output logic             m2w_flush,
    output logic             hold_active,
    output logic [CNT_W-1:0] cnt_dc,
    output logic [CNT_W-1:0] cnt_ic,
    output logic [CNT_W-1:0] cnt_lu,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int unsigned HOLD_W = (RESET_HOLD_CYCLES > 0) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;

    typedef enum logic {ST_HOLD, ST_RUN} state_e;

    localparam state_e            RESET_STATE = (RESET_HOLD_CYCLES == 0) ? ST_RUN : ST_HOLD;
    localparam logic [HOLD_W-1:0] HOLD_INIT   = HOLD_W'(RESET_HOLD_CYCLES);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pend_flush_q, pend_flush_d;

    logic load_use;
    logic fire_dc, fire_ic, fire_lu, fire_flush;

    // $zero is never a real producer, so it can never create a load-use hazard.
    assign load_use = ex_is_load && ex_uses_rw && (ex_rw_addr != 5'd0) &&
                      ((dec_uses_rs && (dec_rs_addr == ex_rw_addr)) ||
                       (dec_uses_rt && (dec_rt_addr == ex_rw_addr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            hold_cnt_q   <= HOLD_INIT;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        pend_flush_d = pend_flush_q;
        pc_stall     = 1'b0;
        i2d_stall    = 1'b0;
        i2d_flush    = 1'b0;
        d2e_stall    = 1'b0;
        d2e_flush    = 1'b0;
        e2m_stall    = 1'b0;
        e2m_flush    = 1'b0;
        m2w_stall    = 1'b0;
        m2w_flush    = 1'b0;
        hold_active  = 1'b0;
        fire_dc      = 1'b0;
        fire_ic      = 1'b0;
        fire_lu      = 1'b0;
        fire_flush   = 1'b0;

        case (state_q)
            ST_HOLD: begin
                // Freeze the whole pipe while the caches initialise; all hazard inputs are ignored.
                pc_stall    = 1'b1;
                i2d_stall   = 1'b1;
                d2e_stall   = 1'b1;
                e2m_stall   = 1'b1;
                m2w_stall   = 1'b1;
                hold_active = 1'b1;
                hold_cnt_d  = hold_cnt_q - HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (dc_miss) begin
                    // MEM is blocked: hold everything behind it and bubble WB.
                    fire_dc   = 1'b1;
                    pc_stall  = 1'b1;
                    i2d_stall = 1'b1;
                    d2e_stall = 1'b1;
                    e2m_stall = 1'b1;
                    m2w_flush = 1'b1;
                    // i2d/d2e are stalled and would drop a flush, so remember it.
                    if (ex_mispredict) begin
                        pend_flush_d = 1'b1;
                    end
                end else if (ex_mispredict || pend_flush_q) begin
                    fire_flush   = 1'b1;
                    i2d_flush    = 1'b1;
                    d2e_flush    = 1'b1;
                    pc_stall     = ic_miss;
                    pend_flush_d = 1'b0;
                end else if (load_use) begin
                    fire_lu   = 1'b1;
                    pc_stall  = 1'b1;
                    i2d_stall = 1'b1;
                    d2e_flush = 1'b1;
                end else if (ic_miss) begin
                    fire_ic   = 1'b1;
                    pc_stall  = 1'b1;
                    i2d_flush = 1'b1;
                end
            end
        endcase
    end

`ifdef HAZARD_SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] cnt_dc_q, cnt_ic_q, cnt_lu_q, cnt_flush_q;

    // Saturating: once all-ones, a counter stays there instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_dc_q    <= '0;
            cnt_ic_q    <= '0;
            cnt_lu_q    <= '0;
            cnt_flush_q <= '0;
        end else begin
            if (fire_dc && (cnt_dc_q != '1)) begin
                cnt_dc_q <= cnt_dc_q + CNT_W'(1);
            end
            if (fire_ic && (cnt_ic_q != '1)) begin
                cnt_ic_q <= cnt_ic_q + CNT_W'(1);
            end
            if (fire_lu && (cnt_lu_q != '1)) begin
                cnt_lu_q <= cnt_lu_q + CNT_W'(1);
            end
            if (fire_flush && (cnt_flush_q != '1)) begin
                cnt_flush_q <= cnt_flush_q + CNT_W'(1);
            end
        end
    end

    assign cnt_dc    = cnt_dc_q;
    assign cnt_ic    = cnt_ic_q;
    assign cnt_lu    = cnt_lu_q;
    assign cnt_flush = cnt_flush_q;
`else
    logic unused_fire;
    assign unused_fire = ^{fire_dc, fire_ic, fire_lu, fire_flush};

    assign cnt_dc    = '0;
    assign cnt_ic    = '0;
    assign cnt_lu    = '0;
    assign cnt_flush = '0;
`endif

endmodule
